lfsr_stream_checker: RTL

Consumer-side checker for the LFSR→FIFO data path. Pops 4-bit words from the FIFO and regenerates the expected sequence with a local Galois LFSR identical to the producer's. Compares each popped word with the expected word and reports mismatches and error/word counts. Sits on the FIFO read side, replacing the button-driven pop in self-test builds.

---
 rtl/lfsr_stream_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/lfsr_stream_checker.sv
// Consumer-side checker: pops FIFO words, regenerates the producer's Galois LFSR
// sequence, and counts words/mismatches. Optional macro: LFSR_CHECKER_TIMEOUT_EN.
module lfsr_stream_checker #(
    parameter int                    LFSR_WIDTH     = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = 1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS      = 8'hB8,
    parameter int                    WORD_WIDTH     = 4,
    parameter int                    CNT_WIDTH      = 16,
    parameter int                    TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  fifo_pop,
    output logic                  busy,
    output logic                  mismatch,
    output logic [WORD_WIDTH-1:0] expected,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  timeout
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_walk;
    logic [WORD_WIDTH-1:0] word;
    logic [CNT_WIDTH-1:0]  err_q, err_d, wc_q, wc_d;
    logic                  mm_q, mm_d;
    logic                  to_hit;

    // Walk WORD_WIDTH Galois steps from the current state; first bit out lands in bit 0.
    always_comb begin
        lfsr_walk = lfsr_q;
        word      = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            word[i]   = lfsr_walk[0];
            lfsr_walk = lfsr_walk >> 1;
            if (word[i]) lfsr_walk = lfsr_walk ^ LFSR_TAPS;
        end
    end

`ifdef LFSR_CHECKER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    assign to_hit = (state_q == S_WAIT) && !fifo_data_valid &&
                    (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + TO_W'(1) : '0;
        timeout_d  = timeout_q | to_hit;
        if (clear) begin
            wait_cnt_d = '0;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        err_d   = err_q;
        wc_d    = wc_q;
        mm_d    = 1'b0;
        case (state_q)
            S_IDLE: if (enable && !fifo_empty) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (fifo_data_valid) begin
                    state_d = S_IDLE;
                    lfsr_d  = lfsr_walk;
                    wc_d    = wc_q + CNT_WIDTH'(1);
                    if (fifo_data != word) begin
                        mm_d = 1'b1;
                        if (!(&err_q)) err_d = err_q + CNT_WIDTH'(1);
                    end
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A word arriving together with clear is dropped.
        if (clear) begin
            state_d = S_IDLE;
            lfsr_d  = LFSR_SEED;
            err_d   = '0;
            wc_d    = '0;
            mm_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            err_q   <= '0;
            wc_q    <= '0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            err_q   <= err_d;
            wc_q    <= wc_d;
            mm_q    <= mm_d;
        end
    end

    assign fifo_pop   = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign mismatch   = mm_q;
    assign expected   = word;
    assign err_count  = err_q;
    assign word_count = wc_q;

endmodule
